// File: rtl/rice_core_pkg.sv
// Shared types and limits for the rice core front-end hazard controller.
package rice_core_pkg;

    // Sequencing states of the hazard controller; encodings are visible on the debug port.
    typedef enum logic [1:0] {
        HAZ_STARTUP  = 2'd0,
        HAZ_RUN      = 2'd1,
        HAZ_MEM_WAIT = 2'd2,
        HAZ_REDIRECT = 2'd3
    } rice_core_hazard_state;

    // Architectural register index (x0..x31).
    typedef logic [4:0] rice_core_reg_index;

    localparam int RICE_CORE_HAZARD_FLUSH_CYCLES_MAX   = 7;
    localparam int RICE_CORE_HAZARD_STARTUP_CYCLES_MAX = 15;

    // True when a producer writing rd feeds a consumer reading rs; x0 never matches.
    function automatic logic rice_core_reg_match(input rice_core_reg_index rd,
                                                 input rice_core_reg_index rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/rice_core_hazard_controller_if.sv
// Bundle of pipeline status inputs and stall/bubble/flush controls for the hazard controller.
// master: the pipeline side that reports stage contents; slave: the hazard controller.
interface rice_core_hazard_controller_if;
    import rice_core_pkg::*;

    logic               i_enable;
    logic               i_if_valid;
    rice_core_reg_index i_if_rs1;
    rice_core_reg_index i_if_rs2;
    logic               i_if_csr;
    logic               i_id_valid;
    rice_core_reg_index i_id_rd;
    logic               i_id_load;
    logic               i_ex_valid;
    rice_core_reg_index i_ex_rd;
    logic               i_ex_load;
    logic               i_ex_redirect;
    logic               i_mem_busy;
    logic               o_stall;
    logic               o_bubble;
    logic               o_flush;
    logic [1:0]         o_state;

    modport master (
        output i_enable, i_if_valid, i_if_rs1, i_if_rs2, i_if_csr,
               i_id_valid, i_id_rd, i_id_load,
               i_ex_valid, i_ex_rd, i_ex_load, i_ex_redirect, i_mem_busy,
        input  o_stall, o_bubble, o_flush, o_state
    );

    modport slave (
        input  i_enable, i_if_valid, i_if_rs1, i_if_rs2, i_if_csr,
               i_id_valid, i_id_rd, i_id_load,
               i_ex_valid, i_ex_rd, i_ex_load, i_ex_redirect, i_mem_busy,
        output o_stall, o_bubble, o_flush, o_state
    );

endinterface

// File: rtl/rice_core_raw_checker.sv
// Combinational RAW detector: does the IF instruction read a register that ID or EX will write?
module rice_core_raw_checker
    import rice_core_pkg::*;
(
    input  rice_core_reg_index rs1,
    input  rice_core_reg_index rs2,
    input  logic               id_valid,
    input  rice_core_reg_index id_rd,
    input  logic               ex_valid,
    input  rice_core_reg_index ex_rd,
    output logic               hit_id,
    output logic               hit_ex
);

    // A valid producer hits when its destination matches either source (x0 excluded).
    always_comb begin
        hit_id = id_valid & (rice_core_reg_match(id_rd, rs1) | rice_core_reg_match(id_rd, rs2));
        hit_ex = ex_valid & (rice_core_reg_match(ex_rd, rs1) | rice_core_reg_match(ex_rd, rs2));
    end

endmodule

// File: rtl/rice_core_hazard_controller.sv
// Front-end sequencing controller for the rice core (IF -> ID -> EX).
// Generates stall/bubble/flush for IF and ID from RAW hazards, CSR serialisation,
// redirect flushes, data-memory waits and the post-reset start-up hold.
// Optional build macro RICE_CORE_HAZARD_PERF_EN adds saturating stall/flush counters.
module rice_core_hazard_controller
    import rice_core_pkg::*;
#(
    parameter int FORWARDING     = 1,
    parameter int FLUSH_CYCLES   = 2,
    parameter int STARTUP_CYCLES = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    rice_core_hazard_controller_if.slave bus
`ifdef RICE_CORE_HAZARD_PERF_EN
    ,
    output logic [31:0]                o_stall_cycles,
    output logic [31:0]                o_flush_events
`endif
);

    localparam logic [3:0] STARTUP_LOAD = 4'(STARTUP_CYCLES - 1);
    localparam logic [3:0] FLUSH_LOAD   = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

    rice_core_hazard_state state;
    logic [3:0]            count;

    logic hit_id;
    logic hit_ex;
    logic interlock;
    logic csr_drain;

    logic                  run_stall;
    logic                  run_bubble;
    logic                  run_flush;
    logic                  run_redirect;
    rice_core_hazard_state run_next;

    logic stall;
    logic bubble;
    logic flush;

    rice_core_raw_checker u_raw_checker (
        .rs1      (bus.i_if_rs1),
        .rs2      (bus.i_if_rs2),
        .id_valid (bus.i_id_valid),
        .id_rd    (bus.i_id_rd),
        .ex_valid (bus.i_ex_valid),
        .ex_rd    (bus.i_ex_rd),
        .hit_id   (hit_id),
        .hit_ex   (hit_ex)
    );

    // With forwarding only a load in ID cannot be bypassed in time; without it any producer blocks.
    assign interlock = (FORWARDING != 0) ? (hit_id & bus.i_id_load) : (hit_id | hit_ex);
    assign csr_drain = bus.i_if_valid & bus.i_if_csr & (bus.i_id_valid | bus.i_ex_valid);

    // Prioritised RUN-state decision, also reused on the cycle memory releases MEM_WAIT.
    always_comb begin
        run_stall    = 1'b0;
        run_bubble   = 1'b0;
        run_flush    = 1'b0;
        run_redirect = 1'b0;
        run_next     = HAZ_RUN;
        if (!bus.i_enable) begin
            run_stall  = 1'b1;
            run_bubble = 1'b1;
        end else if (bus.i_mem_busy) begin
            run_stall = 1'b1;
            run_next  = HAZ_MEM_WAIT;
        end else if (bus.i_ex_redirect) begin
            run_flush    = 1'b1;
            run_redirect = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                run_next = HAZ_REDIRECT;
            end
        end else if (csr_drain) begin
            run_stall  = 1'b1;
            run_bubble = 1'b1;
        end else if (interlock & bus.i_if_valid) begin
            run_stall  = 1'b1;
            run_bubble = 1'b1;
        end
    end

    // Map the current state to the stage controls driven this cycle.
    always_comb begin
        stall  = 1'b0;
        bubble = 1'b0;
        flush  = 1'b0;
        case (state)
            HAZ_STARTUP: begin
                stall  = 1'b1;
                bubble = 1'b1;
            end
            HAZ_RUN: begin
                stall  = run_stall;
                bubble = run_bubble;
                flush  = run_flush;
            end
            HAZ_MEM_WAIT: begin
                if (bus.i_mem_busy) begin
                    stall = 1'b1;
                end else begin
                    stall  = run_stall;
                    bubble = run_bubble;
                    flush  = run_flush;
                end
            end
            HAZ_REDIRECT: begin
                flush = 1'b1;
            end
            default: begin
                stall  = 1'b1;
                bubble = 1'b1;
            end
        endcase
    end

    assign bus.o_stall  = stall;
    assign bus.o_bubble = bubble;
    assign bus.o_flush  = flush;
    assign bus.o_state  = state;

    // Sequencing FSM: start-up hold, run, memory wait and multi-cycle redirect flush.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= HAZ_STARTUP;
            count <= STARTUP_LOAD;
        end else begin
            case (state)
                HAZ_STARTUP: begin
                    if (bus.i_enable) begin
                        if (count == 4'd0) begin
                            state <= HAZ_RUN;
                        end else begin
                            count <= count - 4'd1;
                        end
                    end
                end
                HAZ_RUN: begin
                    state <= run_next;
                    if (run_redirect) begin
                        count <= FLUSH_LOAD;
                    end
                end
                HAZ_MEM_WAIT: begin
                    if (!bus.i_mem_busy) begin
                        state <= run_next;
                        if (run_redirect) begin
                            count <= FLUSH_LOAD;
                        end
                    end
                end
                HAZ_REDIRECT: begin
                    if (bus.i_ex_redirect) begin
                        count <= FLUSH_LOAD;
                    end else if (count == 4'd0) begin
                        state <= HAZ_RUN;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: begin
                    state <= HAZ_STARTUP;
                    count <= STARTUP_LOAD;
                end
            endcase
        end
    end

`ifdef RICE_CORE_HAZARD_PERF_EN
    logic stall_event;
    logic flush_event;

    assign stall_event = stall & (state != HAZ_STARTUP);
    assign flush_event = ((state != HAZ_REDIRECT) & flush) |
                         ((state == HAZ_REDIRECT) & bus.i_ex_redirect);

    // Saturating performance counters for stall cycles and flush sequences.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_stall_cycles <= 32'd0;
            o_flush_events <= 32'd0;
        end else begin
            if (stall_event && (o_stall_cycles != 32'hFFFF_FFFF)) begin
                o_stall_cycles <= o_stall_cycles + 32'd1;
            end
            if (flush_event && (o_flush_events != 32'hFFFF_FFFF)) begin
                o_flush_events <= o_flush_events + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/rice_core_hazard_controller.md
Name: rice_core_hazard_controller

Overview:
Pipeline sequencing controller for the rice core front end (IF → ID → EX). It produces the stall, bubble and flush controls consumed by the IF and ID stages. It detects RAW hazards between the instruction in IF (about to be decoded and read from the register file) and in-flight producers in ID/EX, serialises CSR accesses, and sequences redirect flushes, data-memory waits and post-reset start-up.

Parameters:
- FORWARDING, 1: 1 = EX/MEM forwarding exists, so only load-use RAW interlocks; 0 = any RAW against a valid ID or EX producer interlocks.
- FLUSH_CYCLES, 2: cycles o_flush is held per redirect (1..7).
- STARTUP_CYCLES, 4: cycles the front end is held after reset (1..15).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_enable  in  1  core enable
- i_if_valid  in  1  IF holds a valid instruction
- i_if_rs1  in  5  source register 1 of the IF instruction (0 = unused)
- i_if_rs2  in  5  source register 2 of the IF instruction (0 = unused)
- i_if_csr  in  1  IF instruction is a CSR/SYSTEM access
- i_id_valid  in  1  ID result valid
- i_id_rd  in  5  ID destination register
- i_id_load  in  1  ID instruction is a load
- i_ex_valid  in  1  EX result valid
- i_ex_rd  in  5  EX destination register
- i_ex_load  in  1  EX instruction is a load
- i_ex_redirect  in  1  EX resolved a jump or taken branch
- i_mem_busy  in  1  data memory has not yet answered the current access
- o_stall  out  1  hold IF and ID registers
- o_bubble  out  1  ID inserts an invalid result this cycle
- o_flush  out  1  invalidate IF and ID contents
- o_state  out  2  FSM state (debug)

Behaviour:
- One clock (i_clk); reset i_rst is synchronous and active-high.
- FSM states: STARTUP=0, RUN=1, MEM_WAIT=2, REDIRECT=3.
- Reset: state=STARTUP, counter=STARTUP_CYCLES-1, o_stall=1, o_bubble=1, o_flush=0.
- STARTUP: o_stall=1, o_bubble=1; counter decrements each cycle; at 0 → RUN. i_enable=0 freezes the counter.
- RUN, outputs combinational, evaluated in priority order:
  1. !i_enable → o_stall=1, o_bubble=1.
  2. i_mem_busy → o_stall=1, o_bubble=0 (EX holds); next state MEM_WAIT.
  3. i_ex_redirect → o_flush=1, o_stall=0; if FLUSH_CYCLES>1, next state REDIRECT with counter=FLUSH_CYCLES-2.
  4. CSR drain: i_if_valid & i_if_csr & (i_id_valid | i_ex_valid) → o_stall=1, o_bubble=1.
  5. RAW: hit_id = i_id_valid & rd≠0 & rd∈{rs1,rs2}; hit_ex is the same test on EX.
     - FORWARDING=1: interlock = hit_id & i_id_load.
     - FORWARDING=0: interlock = hit_id | hit_ex.
     - interlock & i_if_valid → o_stall=1, o_bubble=1.
  6. Otherwise all outputs 0.
- MEM_WAIT: o_stall=1, o_bubble=0 until i_mem_busy=0; that cycle outputs are re-evaluated as RUN and the state returns to RUN. A redirect seen in MEM_WAIT is ignored; EX holds it until memory completes.
- REDIRECT: o_flush=1, o_stall=0; counter decrements; at 0 → RUN. A new i_ex_redirect reloads the counter.
- Register x0 never creates a hazard.
- Load-use latency: exactly one bubble when FORWARDING=1.
- Reset asserted mid-operation → STARTUP next cycle regardless of state.

Optional Feature:
- Macro: RICE_CORE_HAZARD_PERF_EN.
- Defined: adds outputs o_stall_cycles (32) and o_flush_events (32), saturating counters cleared on i_rst.
  - o_stall_cycles +1 each cycle with o_stall=1 outside STARTUP.
  - o_flush_events +1 on each RUN→flush entry or REDIRECT reload.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- rice_core_pkg gains: rice_core_hazard_state enum (2 bits), rice_core_reg_index typedef (5 bits), RICE_CORE_HAZARD_FLUSH_CYCLES_MAX=7.
- One sub-module, rice_core_raw_checker: combinational hit_id/hit_ex computation, instantiated once.

Test Plan:
- Reset held 3 cycles, then released → o_stall=1 for exactly 4 cycles, then o_state=RUN and o_stall=0.
- FORWARDING=1: ID load rd=5, IF rs2=5 → one cycle of o_stall=1/o_bubble=1. Same with ID non-load → no stall. rd=0 with rs1=0 → no stall.
- FORWARDING=0: EX rd=7 (non-load), IF rs1=7 → stall while EX is valid.
- i_ex_redirect pulse with FLUSH_CYCLES=2 → o_flush high for 2 cycles. A second redirect in cycle 2 extends it to 3.
- i_mem_busy high for 5 cycles while a redirect is pending → o_stall=1 for 5 cycles, o_flush=0, then flush on release.
- IF CSR with ID and EX valid → stall until both are invalid. With RICE_CORE_HAZARD_PERF_EN, o_stall_cycles matches the stall count.
